// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequences MEM-stage loads and stores onto a req/gnt/rvalid data-memory
//   port, one access outstanding. Accesses that cross a word boundary are
//   either split into two word accesses (SPLIT_EN=1) or rejected with a
//   one-cycle misalignedErr pulse (SPLIT_EN=0).
// Ports
//   clk, arstn                 clock, async active-low reset
//   memValid/memWe/memSize/
//   memUnsigned/memAddr/
//   memWData                   MEM-stage access, held while stallMEM=1
//   stallMEM                   freeze IF..MEM and MEM/WB
//   misalignedErr              rejected crossing access (SPLIT_EN=0 only)
//   dmLoadData                 registered, extended load result for WB
//   dmReq/dmWe/dmAddr/
//   dmByteEn/dmWData           memory request side
//   dmGnt/dmRvalid/dmRData     memory response side
module dmem_access_ctrl #(
  parameter int SPLIT_EN = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              memValid,
  input  logic              memWe,
  input  logic [1:0]        memSize,
  input  logic              memUnsigned,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [31:0]       memWData,
  output logic              stallMEM,
  output logic              misalignedErr,
  output logic [31:0]       dmLoadData,
  output logic              dmReq,
  output logic              dmWe,
  output logic [ADDR_W-1:0] dmAddr,
  output logic [3:0]        dmByteEn,
  output logic [31:0]       dmWData,
  input  logic              dmGnt,
  input  logic              dmRvalid,
  input  logic [31:0]       dmRData
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, FIN} state_t;

  localparam bit SPLIT = (SPLIT_EN != 0);

  state_t      st_q, st_d;
  logic [31:0] asm_q, asm_d;
  logic        asm_en;
  logic        ld_en;
  logic [31:0] ld_val, ld_ext;

  // Access geometry. The MEM stage holds its inputs while stalled, so the
  // geometry is derived straight from them instead of being captured.
  logic [1:0]        o;
  logic [3:0]        m;
  logic [7:0]        m_sh;
  logic              crosses, reject;
  logic [5:0]        sh_lo, sh_hi;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       asm_first, asm_second;

  assign o = memAddr[1:0];

  always_comb begin
    case (memSize)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;   // size 3 behaves as word
    endcase
  end

  // Upper nibble of the shifted mask holds the lanes that spill into the
  // next word; non-zero exactly when the access crosses a boundary.
  assign m_sh    = {4'b0000, m} << o;
  assign crosses = (m_sh[7:4] != 4'b0000);
  assign reject  = crosses && !SPLIT;

  assign sh_lo = {o, 3'b000};
  assign sh_hi = 6'd32 - sh_lo;

  assign addr0 = {memAddr[ADDR_W-1:2], 2'b00};
  assign addr1 = addr0 + ADDR_W'(4);

  assign asm_first  = dmRData >> sh_lo;
  assign asm_second = asm_q | (dmRData << sh_hi);

  always_comb begin
    st_d          = st_q;
    stallMEM      = 1'b0;
    misalignedErr = 1'b0;
    dmReq         = 1'b0;
    dmWe          = 1'b0;
    dmAddr        = '0;
    dmByteEn      = 4'b0000;
    dmWData       = 32'h0;
    asm_en        = 1'b0;
    asm_d         = asm_first;
    ld_en         = 1'b0;
    ld_val        = asm_first;
    case (st_q)
      IDLE: begin
        if (memValid) begin
          if (reject) begin
            misalignedErr = 1'b1;
          end else begin
            stallMEM = 1'b1;
            st_d     = REQ0;
          end
        end
      end
      REQ0: begin
        stallMEM = 1'b1;
        dmReq    = 1'b1;
        dmWe     = memWe;
        dmAddr   = addr0;
        dmByteEn = m_sh[3:0];
        dmWData  = memWData << sh_lo;
        if (dmGnt) st_d = WAIT0;
      end
      WAIT0: begin
        stallMEM = 1'b1;
        if (dmRvalid) begin
          asm_en = 1'b1;
          asm_d  = asm_first;
          if (crosses) begin
            st_d = REQ1;
          end else begin
            st_d   = FIN;
            ld_en  = !memWe;
            ld_val = asm_first;
          end
        end
      end
      REQ1: begin
        stallMEM = 1'b1;
        dmReq    = 1'b1;
        dmWe     = memWe;
        dmAddr   = addr1;
        dmByteEn = m_sh[7:4];
        dmWData  = memWData >> sh_hi;
        if (dmGnt) st_d = WAIT1;
      end
      WAIT1: begin
        stallMEM = 1'b1;
        if (dmRvalid) begin
          asm_en = 1'b1;
          asm_d  = asm_second;
          st_d   = FIN;
          ld_en  = !memWe;
          ld_val = asm_second;
        end
      end
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Size mask plus sign/zero extension of the assembled word.
  always_comb begin
    case (memSize)
      2'd0:    ld_ext = memUnsigned ? {24'h0, ld_val[7:0]}
                                    : {{24{ld_val[7]}}, ld_val[7:0]};
      2'd1:    ld_ext = memUnsigned ? {16'h0, ld_val[15:0]}
                                    : {{16{ld_val[15]}}, ld_val[15:0]};
      default: ld_ext = ld_val;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      st_q       <= IDLE;
      asm_q      <= 32'h0;
      dmLoadData <= 32'h0;
    end else begin
      st_q <= st_d;
      if (asm_en) asm_q <= asm_d;
      if (ld_en)  dmLoadData <= ld_ext;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        memValid = 1'b0, memValid1 = 1'b0;
  logic        memWe = 1'b0;
  logic [1:0]  memSize = 2'd0;
  logic        memUnsigned = 1'b0;
  logic [31:0] memAddr = 32'h0;
  logic [31:0] memWData = 32'h0;

  logic        stall0, err0, dmReq, dmWe;
  logic [31:0] dmLoadData, dmAddr, dmWData;
  logic [3:0]  dmByteEn;
  logic        dmGnt = 1'b0, dmRvalid = 1'b0;
  logic [31:0] dmRData = 32'h0;

  logic        stall1, err1, dmReq1, dmWe1;
  logic [31:0] dmLoadData1, dmAddr1, dmWData1;
  logic [3:0]  dmByteEn1;
  logic        gnt1 = 1'b0, rv1 = 1'b0;
  logic [31:0] rd1 = 32'h0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.SPLIT_EN(1), .ADDR_W(32)) dut (
    .clk(clk), .arstn(arstn), .memValid(memValid), .memWe(memWe),
    .memSize(memSize), .memUnsigned(memUnsigned), .memAddr(memAddr),
    .memWData(memWData), .stallMEM(stall0), .misalignedErr(err0),
    .dmLoadData(dmLoadData), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
    .dmByteEn(dmByteEn), .dmWData(dmWData), .dmGnt(dmGnt),
    .dmRvalid(dmRvalid), .dmRData(dmRData));

  dmem_access_ctrl #(.SPLIT_EN(0), .ADDR_W(32)) dut_nosplit (
    .clk(clk), .arstn(arstn), .memValid(memValid1), .memWe(memWe),
    .memSize(memSize), .memUnsigned(memUnsigned), .memAddr(memAddr),
    .memWData(memWData), .stallMEM(stall1), .misalignedErr(err1),
    .dmLoadData(dmLoadData1), .dmReq(dmReq1), .dmWe(dmWe1), .dmAddr(dmAddr1),
    .dmByteEn(dmByteEn1), .dmWData(dmWData1), .dmGnt(gnt1),
    .dmRvalid(rv1), .dmRData(rd1));

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: 256 words indexed by addr[9:2]; logs every granted request.
  logic [31:0] mem [256];
  int          gnt_dly = 0, rv_dly = 1;
  int          req_n = 0;
  logic [31:0] log_a [4];
  logic [3:0]  log_b [4];
  logic [31:0] log_w [4];
  logic        log_we [4];

  initial begin
    int gcnt, pcnt;
    bit pend;
    logic [31:0] rd_lat;
    gcnt = 0; pcnt = 0; pend = 0; rd_lat = 32'h0;
    forever begin
      @(negedge clk);
      dmGnt = 1'b0;
      dmRvalid = 1'b0;
      if (pend) begin
        pcnt--;
        if (pcnt <= 0) begin
          dmRvalid = 1'b1;
          dmRData  = rd_lat;
          pend     = 0;
        end
      end else if (dmReq) begin
        if (gcnt < gnt_dly) gcnt++;
        else begin
          dmGnt = 1'b1;
          gcnt  = 0;
          if (req_n < 4) begin
            log_a[req_n] = dmAddr; log_b[req_n] = dmByteEn;
            log_w[req_n] = dmWData; log_we[req_n] = dmWe;
          end
          req_n++;
          if (dmWe) begin
            for (int b = 0; b < 4; b++)
              if (dmByteEn[b]) mem[dmAddr[9:2]][8*b +: 8] = dmWData[8*b +: 8];
          end
          rd_lat = mem[dmAddr[9:2]];
          pend = 1;
          pcnt = rv_dly;
        end
      end
    end
  end

  int stalls, errs, reqs1;

  // Present one access (sel=1 -> SPLIT_EN=0 instance), hold it while stalled,
  // drop it on the first non-stalled cycle, return sampled at the next cycle.
  task automatic do_acc(input bit sel, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    bit done, s;
    done = 0;
    @(negedge clk);
    memWe = we; memSize = sz; memUnsigned = uns; memAddr = a; memWData = wd;
    if (sel) memValid1 = 1'b1; else memValid = 1'b1;
    req_n = 0; stalls = 0; errs = 0; reqs1 = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      s = sel ? stall1 : stall0;
      if (s) stalls++;
      if (sel ? err1 : err0) errs++;
      if (sel && dmReq1) reqs1++;
      if (!s) begin done = 1; break; end
      @(negedge clk);
    end
    memValid = 1'b0; memValid1 = 1'b0;
    if (!done) chk("access timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    bit          stable;
    int          n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // reset state
    #12;
    chk("rst dmReq", {31'h0, dmReq}, 32'h0);
    chk("rst stall", {31'h0, stall0}, 32'h0);
    chk("rst err", {31'h0, err0}, 32'h0);
    chk("rst loaddata", dmLoadData, 32'h0);
    chk("rst addr/be/wd", dmAddr | {28'h0, dmByteEn} | dmWData | {31'h0, dmWe}, 32'h0);
    #10 arstn = 1'b1;

    // 1: LW 0x100
    mem[8'h40] = 32'hDEADBEEF;
    do_acc(0, 0, 2'd2, 0, 32'h100, 32'h0);
    chk("t1 stalls", stalls, 3);
    chk("t1 reqs", req_n, 1);
    chk("t1 addr", log_a[0], 32'h100);
    chk("t1 be", {28'h0, log_b[0]}, 32'hF);
    chk("t1 data", dmLoadData, 32'hDEADBEEF);

    // 2: LB / LBU / LH around 0x102..0x103
    mem[8'h40] = 32'h80FFFFFF;
    do_acc(0, 0, 2'd0, 0, 32'h103, 32'h0);
    chk("t2 lb be", {28'h0, log_b[0]}, 32'h8);
    chk("t2 lb data", dmLoadData, 32'hFFFFFF80);
    do_acc(0, 0, 2'd0, 1, 32'h103, 32'h0);
    chk("t2 lbu data", dmLoadData, 32'h00000080);
    do_acc(0, 0, 2'd1, 0, 32'h102, 32'h0);
    chk("t2 lh data", dmLoadData, 32'hFFFF80FF);

    // 3: SH 0x102
    do_acc(0, 1, 2'd1, 0, 32'h102, 32'h0000ABCD);
    chk("t3 reqs", req_n, 1);
    chk("t3 be", {28'h0, log_b[0]}, 32'hC);
    chk("t3 wdata", log_w[0], 32'hABCD0000);
    chk("t3 we", {31'h0, log_we[0]}, 32'h1);
    chk("t3 stalls", stalls, 3);
    chk("t3 loaddata kept", dmLoadData, 32'hFFFF80FF);
    chk("t3 mem", mem[8'h40], 32'hABCDFFFF);

    // 4: split LW 0x0FE
    mem[8'h3F] = 32'h3344AAAA;
    mem[8'h40] = 32'hBBBB1122;
    do_acc(0, 0, 2'd2, 0, 32'h0FE, 32'h0);
    chk("t4 reqs", req_n, 2);
    chk("t4 addr0", log_a[0], 32'h0FC);
    chk("t4 be0", {28'h0, log_b[0]}, 32'hC);
    chk("t4 addr1", log_a[1], 32'h100);
    chk("t4 be1", {28'h0, log_b[1]}, 32'h3);
    chk("t4 stalls", stalls, 5);
    chk("t4 data", dmLoadData, 32'h11223344);

    // 5: same access, SPLIT_EN=0 instance
    do_acc(1, 0, 2'd2, 0, 32'h0FE, 32'h0);
    chk("t5 err cycles", errs, 1);
    chk("t5 stalls", stalls, 0);
    chk("t5 reqs", reqs1, 0);
    chk("t5 err after", {31'h0, err1}, 32'h0);

    // 6: delayed grant, reset during WAIT0, late rvalid ignored
    mem[8'h10] = 32'h12345678;
    gnt_dly = 4;
    rv_dly  = $urandom_range(2, 5);
    @(negedge clk);
    memWe = 1'b0; memSize = 2'd2; memUnsigned = 1'b0; memAddr = 32'h40; memWData = 32'h0;
    memValid = 1'b1;
    @(negedge clk); #1;
    chk("t6 req", {31'h0, dmReq}, 32'h1);
    a0 = dmAddr; b0 = dmByteEn; w0 = dmWData;
    stable = 1; n = 0;
    while (!dmGnt && n < 20) begin
      @(negedge clk); #1;
      n++;
      if (!(dmReq && dmAddr == a0 && dmByteEn == b0 && dmWData == w0)) stable = 0;
    end
    chk("t6 gnt wait", n, 4);
    chk("t6 stable", {31'h0, stable}, 32'h1);
    @(negedge clk); #1;
    chk("t6 wait0 req", {31'h0, dmReq}, 32'h0);
    chk("t6 wait0 stall", {31'h0, stall0}, 32'h1);
    arstn = 1'b0;
    #1;
    chk("t6 rst req", {31'h0, dmReq}, 32'h0);
    chk("t6 rst data", dmLoadData, 32'h0);
    memValid = 1'b0;
    #1 arstn = 1'b1;
    gnt_dly = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("t6 late rvalid data", dmLoadData, 32'h0);
    chk("t6 idle req", {31'h0, dmReq}, 32'h0);
    chk("t6 idle stall", {31'h0, stall0}, 32'h0);

    // recovery after reset: LBU 0x41
    rv_dly = 1;
    do_acc(0, 0, 2'd0, 1, 32'h41, 32'h0);
    chk("t6 recover stalls", stalls, 3);
    chk("t6 recover data", dmLoadData, 32'h00000056);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
